// File: rtl/draw_seq_pkg.sv
// Shared types and constants for the draw sequencer.
package draw_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StRst,
    StRun,
    StRel,
    StFin
  } state_t;

  localparam int unsigned VGA_XW = 8;
  localparam int unsigned VGA_YW = 7;
  localparam int unsigned VGA_CW = 3;

  // Visible screen limits of the VGA adapter.
  localparam int unsigned X_MAX = 159;
  localparam int unsigned Y_MAX = 119;

endpackage

// File: rtl/next_job_finder.sv
// Combinational search for the lowest enabled engine at or above a start index.
module next_job_finder #(
  parameter int unsigned NUM_ENG = 3,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_ENG-1:0] mask,
  input  logic [IW-1:0]      from,
  output logic               found,
  output logic [IW-1:0]      idx
);

  // Scan from the top down so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Runs enabled drawing engines one at a time and muxes the active one onto the VGA port.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int unsigned NUM_ENG = 3,
  localparam int unsigned IW     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_ENG-1:0]        job_mask,
  output logic                      done,
  output logic                      busy,
  output logic [IW-1:0]             cur_job,
  output logic [NUM_ENG-1:0]        eng_rst_n,
  output logic [NUM_ENG-1:0]        eng_start,
  input  logic [NUM_ENG-1:0]        eng_done,
  input  logic [NUM_ENG*VGA_XW-1:0] eng_x,
  input  logic [NUM_ENG*VGA_YW-1:0] eng_y,
  input  logic [NUM_ENG*VGA_CW-1:0] eng_colour,
  input  logic [NUM_ENG-1:0]        eng_plot,
  output logic [VGA_XW-1:0]         vga_x,
  output logic [VGA_YW-1:0]         vga_y,
  output logic [VGA_CW-1:0]         vga_colour,
  output logic                      vga_plot
);

  state_t             state_q, state_d;
  logic [IW-1:0]      cur_q, cur_d;
  logic [NUM_ENG-1:0] mask_q, mask_d;

  logic               nxt_found;
  logic [IW-1:0]      nxt_idx;
  logic               cur_eng_done;
  logic               cur_eng_plot;
  logic               cur_last;

  next_job_finder #(
    .NUM_ENG (NUM_ENG),
    .IW      (IW)
  ) u_finder (
    .mask  (mask_q),
    .from  (cur_q),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  assign cur_last = (cur_q == IW'(NUM_ENG - 1));
  assign cur_job  = cur_q;

  // State, current index and latched job mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      mask_q  <= mask_d;
    end
  end

  // Next-state logic; dropping start while busy aborts straight to idle.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d  = job_mask;
          cur_d   = '0;
          state_d = StSel;
        end
      end
      StSel: begin
        if (!start) begin
          state_d = StIdle;
        end else if (nxt_found) begin
          cur_d   = nxt_idx;
          state_d = StRst;
        end else begin
          state_d = StFin;
        end
      end
      StRst: state_d = start ? StRun : StIdle;
      StRun: begin
        if (!start)            state_d = StIdle;
        else if (cur_eng_done) state_d = StRel;
      end
      StRel: begin
        if (!start) begin
          state_d = StIdle;
        end else if (!cur_eng_done) begin
          // Last slot finishes the run; cur never wraps past NUM_ENG-1.
          if (cur_last) begin
            state_d = StFin;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = StSel;
          end
        end
      end
      StFin:   if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Per-engine controls and the VGA mux, decoded from state and current index.
  always_comb begin
    eng_rst_n    = '0;
    eng_start    = '0;
    vga_x        = '0;
    vga_y        = '0;
    vga_colour   = '0;
    cur_eng_done = 1'b0;
    cur_eng_plot = 1'b0;
    for (int i = 0; i < int'(NUM_ENG); i++) begin
      eng_rst_n[i] = ~rst & ~((state_q == StRst) && (cur_q == IW'(i)));
      if (cur_q == IW'(i)) begin
        vga_x        = eng_x[i*VGA_XW +: VGA_XW];
        vga_y        = eng_y[i*VGA_YW +: VGA_YW];
        vga_colour   = eng_colour[i*VGA_CW +: VGA_CW];
        cur_eng_done = eng_done[i];
        cur_eng_plot = eng_plot[i];
        eng_start[i] = (state_q == StRun);
      end
    end
    vga_plot = cur_eng_plot & (state_q == StRun);
    busy     = (state_q == StSel) || (state_q == StRst) ||
               (state_q == StRun) || (state_q == StRel);
    done     = (state_q == StFin);
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with behavioural engines and an event scoreboard.
module tb_draw_sequencer;
  import draw_seq_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned IW = 2;
  localparam int          K  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N-1:0]     job_mask;
  logic             done;
  logic             busy;
  logic [IW-1:0]    cur_job;
  logic [N-1:0]     eng_rst_n;
  logic [N-1:0]     eng_start;
  logic [N-1:0]     eng_done;
  logic [N*8-1:0]   eng_x;
  logic [N*7-1:0]   eng_y;
  logic [N*3-1:0]   eng_colour;
  logic [N-1:0]     eng_plot;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [2:0]       vga_colour;
  logic             vga_plot;

  logic [7:0] xs [4];
  logic [6:0] ys [4];
  logic [2:0] cs [4];
  logic [3:0] plot_v;
  int         cnt [N];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  logic [N-1:0] prev_rn = '1;
  logic [N-1:0] prev_st = '0;
  logic         prev_done = 1'b0;
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  assign eng_x      = {xs[2], xs[1], xs[0]};
  assign eng_y      = {ys[2], ys[1], ys[0]};
  assign eng_colour = {cs[2], cs[1], cs[0]};
  assign eng_plot   = plot_v[N-1:0];

  draw_sequencer #(.NUM_ENG(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .job_mask   (job_mask),
    .done       (done),
    .busy       (busy),
    .cur_job    (cur_job),
    .eng_rst_n  (eng_rst_n),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_colour (eng_colour),
    .eng_plot   (eng_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  // Engine model: done rises K edges after start rises, falls one edge after start drops.
  always @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (!eng_rst_n[i]) begin
        cnt[i]      <= 0;
        eng_done[i] <= 1'b0;
      end else if (eng_start[i]) begin
        if (cnt[i] < K) cnt[i] <= cnt[i] + 1;
        if (cnt[i] == K - 1) eng_done[i] <= 1'b1;
      end else begin
        cnt[i]      <= 0;
        eng_done[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Event codes: 0x1i = reset pulse of engine i, 0x2i = start of engine i, 0x30 = done.
  task automatic sb_event(input logic [7:0] ev);
    if (exp_q.size() == 0) check("sb_unexpected_event", {24'b0, ev}, 32'hFFFF_FFFF);
    else                   check("sb_event_order", {24'b0, ev}, {24'b0, exp_q.pop_front()});
  endtask

  // Monitor sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!eng_rst_n[i]) begin
          check("rst_pulse_single_cycle", {31'b0, prev_rn[i]}, 32'd1);
          if (prev_rn[i]) sb_event(8'(8'h10 + i));
        end
        if (eng_start[i] && !prev_st[i]) begin
          sb_event(8'(8'h20 + i));
          check("cur_job_at_start", {30'b0, cur_job}, 32'(i));
        end
      end
      if (done && !prev_done) sb_event(8'h30);
      check("start_onehot0", {31'b0, $onehot0(eng_start)}, 32'd1);
      check("vga_x_mux", {24'b0, vga_x}, {24'b0, xs[cur_job]});
      check("vga_y_mux", {25'b0, vga_y}, {25'b0, ys[cur_job]});
      check("vga_colour_mux", {29'b0, vga_colour}, {29'b0, cs[cur_job]});
      check("vga_plot_gate", {31'b0, vga_plot}, {31'b0, (|eng_start) & plot_v[cur_job]});
    end
    prev_rn   <= eng_rst_n;
    prev_st   <= eng_start;
    prev_done <= done;
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_start(input int idx, input int budget);
    int n = 0;
    while (eng_start[idx] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_start_timeout", {31'b0, eng_start[idx]}, 32'd1);
  endtask

  task automatic finish_run(input string tag);
    @(negedge clk);
    check({tag, "_done_held"}, {31'b0, done}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_idle_done"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_sb_leftover"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    job_mask = '0;
    plot_v   = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 8'(10 * i + 3);
      ys[i] = 7'(20 * i + 5);
      cs[i] = 3'(i + 1);
    end
    xs[3] = '0;
    ys[3] = '0;
    cs[3] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_eng_start", {29'b0, eng_start}, 32'd0);
    check("rst_vga_plot", {31'b0, vga_plot}, 32'd0);
    check("rst_cur_job", {30'b0, cur_job}, 32'd0);
    check("rst_eng_rst_n_low", {29'b0, eng_rst_n}, 32'd0);
    rst = 1'b0;
    #1 check("rst_release_eng_rst_n", {29'b0, eng_rst_n}, 32'h7);
    @(negedge clk);
    mon_en = 1'b1;

    // T1: all three engines in order
    job_mask = 3'b111;
    exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h11);
    exp_q.push_back(8'h21); exp_q.push_back(8'h12); exp_q.push_back(8'h22);
    exp_q.push_back(8'h30);
    start = 1'b1;
    wait_done(300);
    finish_run("T1");

    // T2: engine 1 skipped; later mask change must be ignored
    plot_v   = 4'b0000;
    job_mask = 3'b101;
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h12); exp_q.push_back(8'h22);
    exp_q.push_back(8'h30);
    start = 1'b1;
    @(negedge clk);
    job_mask = 3'b111;
    wait_done(300);
    finish_run("T2");

    // T3: empty mask finishes two edges after start is sampled
    job_mask = 3'b000;
    exp_q.push_back(8'h30);
    start = 1'b1;
    @(negedge clk);
    check("T3_busy_sel", {31'b0, busy}, 32'd1);
    check("T3_done_early", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("T3_done_fin", {31'b0, done}, 32'd1);
    check("T3_busy_fin", {31'b0, busy}, 32'd0);
    check("T3_no_start", {29'b0, eng_start}, 32'd0);
    finish_run("T3");

    // T4: engine 1 plots at the screen corner; plot must only pass during RUN
    plot_v   = 4'b0010;
    xs[1]    = 8'(X_MAX);
    ys[1]    = 7'(Y_MAX);
    job_mask = 3'b010;
    exp_q.push_back(8'h11); exp_q.push_back(8'h21); exp_q.push_back(8'h30);
    start = 1'b1;
    wait_start(1, 50);
    check("T4_run_plot", {31'b0, vga_plot}, 32'd1);
    check("T4_run_x", {24'b0, vga_x}, X_MAX);
    check("T4_run_y", {25'b0, vga_y}, Y_MAX);
    for (int n = 0; n < 50 && eng_start[1] === 1'b1; n++) @(negedge clk);
    check("T4_rel_plot", {31'b0, vga_plot}, 32'd0);
    check("T4_rel_x", {24'b0, vga_x}, X_MAX);
    wait_done(100);
    finish_run("T4");

    // T5: abort mid-RUN of engine 1, then rerun from engine 0
    plot_v   = 4'b0111;
    job_mask = 3'b111;
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    start = 1'b1;
    wait_start(1, 100);
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("T5_abort_eng_start", {29'b0, eng_start}, 32'd0);
    check("T5_abort_plot", {31'b0, vga_plot}, 32'd0);
    check("T5_abort_done", {31'b0, done}, 32'd0);
    check("T5_abort_busy", {31'b0, busy}, 32'd0);
    check("T5_abort_sb_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h11);
    exp_q.push_back(8'h21); exp_q.push_back(8'h12); exp_q.push_back(8'h22);
    exp_q.push_back(8'h30);
    start = 1'b1;
    wait_done(300);
    finish_run("T5");

    // T6: synchronous reset mid-RUN
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    start = 1'b1;
    wait_start(1, 100);
    @(negedge clk);
    mon_en = 1'b0;
    check("T6_sb_leftover", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    #1 check("T6_rst_comb_eng_rst_n", {29'b0, eng_rst_n}, 32'd0);
    @(negedge clk);
    check("T6_busy", {31'b0, busy}, 32'd0);
    check("T6_done", {31'b0, done}, 32'd0);
    check("T6_eng_start", {29'b0, eng_start}, 32'd0);
    check("T6_vga_plot", {31'b0, vga_plot}, 32'd0);
    check("T6_cur_job", {30'b0, cur_job}, 32'd0);
    check("T6_eng_rst_n", {29'b0, eng_rst_n}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("T6_release_eng_rst_n", {29'b0, eng_rst_n}, 32'h7);
    @(negedge clk);
    check("T6_idle_busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
